// File: rtl/prb_pkg.sv
// Shared constants, types and the band offset table for the preamble coefficient loader.
package prb_pkg;

    localparam int PRB_ADDR_W     = 14;
    localparam int PRB_SAMPLES    = 2048;
    localparam int PRB_DW         = 24;
    localparam int PRB_RD_LAT     = 1;
    localparam int PRB_FIFO_DEPTH = 4;
    localparam int PRB_SETTLE     = 2;

    // Highest legal band index; band 5 also selects the zero offset.
    localparam logic [2:0] PRB_BW_MAX  = 3'd5;
    localparam logic [2:0] PRB_BW_NONE = 3'd5;

    typedef logic [PRB_DW-1:0] prb_sample_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_FETCH  = 2'd2,
        ST_DRAIN  = 2'd3
    } prb_state_t;

    // Start of each band inside the preamble sample ROM, in samples.
    function automatic int unsigned prb_bw_offset(input logic [2:0] bw);
        case (bw)
            3'd0:    return 10240;
            3'd1:    return 8192;
            3'd2:    return 6144;
            3'd3:    return 4096;
            3'd4:    return 2048;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/prb_skid_fifo.sv
// Small synchronous FIFO that soaks up ROM samples still in flight when the
// correlator stalls. Push while full is only legal together with a pop.
module prb_skid_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DW         = 24
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_push,
    input  logic [DW-1:0]                      i_din,
    input  logic                               i_pop,
    output logic [DW-1:0]                      o_dout,
    output logic                               o_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    // Storage array; contents need no reset because reads are gated by occupancy.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    // The upstream credit rule must never let a sample arrive into a full FIFO.
    always_ff @(posedge i_clk) begin
        assert (i_rst || !(i_push && w_full && !i_pop));
    end

endmodule

// File: rtl/prb_coef_loader.sv
// Sequencer that selects a band on the preamble ROM, waits for its offset to
// settle, then streams PRB_LEN samples to the correlator coefficient memory.
// Handshake: a coefficient moves on a clock edge where coef_valid && coef_ready;
// coef_valid never waits on coef_ready, and data/address hold while stalled.
module prb_coef_loader
    import prb_pkg::*;
#(
    parameter int DEPTH_RAM  = PRB_ADDR_W,
    parameter int PRB_LEN    = PRB_SAMPLES,
    parameter int DW         = PRB_DW,
    parameter int RD_LAT     = PRB_RD_LAT,
    parameter int FIFO_DEPTH = PRB_FIFO_DEPTH,
    parameter int SETTLE     = PRB_SETTLE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [2:0]                  index_bw_in,
    output logic                        busy,
    output logic                        done,
    output logic                        err_bw,
    output logic [DEPTH_RAM-1:0]        rom_addr,
    output logic [2:0]                  rom_index_bw,
    input  logic [DW-1:0]               rom_dat,
    output logic                        coef_valid,
    input  logic                        coef_ready,
    output logic [$clog2(PRB_LEN)-1:0]  coef_addr,
    output logic [DW-1:0]               coef_data,
    output logic [1:0]                  dbg_state
);

    localparam int CAW = $clog2(PRB_LEN);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int SW  = $clog2(SETTLE + 1);

    prb_state_t            r_state;
    logic [SW-1:0]         r_settle_cnt;
    logic [DEPTH_RAM-1:0]  r_rom_addr;
    logic [2:0]            r_bw;
    logic [RD_LAT-1:0]     r_tag;
    logic [CW-1:0]         r_inflight;
    logic [CAW-1:0]        r_coef_addr;
    logic                  r_done;
    logic                  r_err;

    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [DW-1:0]         w_head;
    logic [CW:0]           w_occ;

    // Credits: samples requested but not yet popped may never exceed the FIFO size.
    assign w_occ   = {1'b0, r_inflight} + {1'b0, w_count};
    assign w_issue = (r_state == ST_FETCH) && (w_occ < (CW+1)'(FIFO_DEPTH));
    assign w_push  = r_tag[RD_LAT-1];
    assign w_pop   = !w_empty && coef_ready;

    prb_skid_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DW         (DW)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_din   (rom_dat),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Control FSM: band latch, settle wait, address walk and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_rom_addr   <= '0;
            r_bw         <= PRB_BW_NONE;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (index_bw_in > PRB_BW_MAX) begin
                            r_err <= 1'b1;
                        end else begin
                            r_bw         <= index_bw_in;
                            r_settle_cnt <= '0;
                            r_state      <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == SW'(SETTLE - 1)) r_state <= ST_FETCH;
                    else                                 r_settle_cnt <= r_settle_cnt + 1'b1;
                end
                ST_FETCH: begin
                    if (w_issue) begin
                        if (r_rom_addr == DEPTH_RAM'(PRB_LEN - 1)) r_state <= ST_DRAIN;
                        else                                       r_rom_addr <= r_rom_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && r_coef_addr == CAW'(PRB_LEN - 1)) begin
                        r_state    <= ST_IDLE;
                        r_done     <= 1'b1;
                        r_rom_addr <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read-latency tag line, in-flight credit count and output index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag       <= '0;
            r_inflight  <= '0;
            r_coef_addr <= '0;
        end else begin
            r_tag      <= RD_LAT'({r_tag, w_issue});
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
            if (w_pop) begin
                r_coef_addr <= (r_coef_addr == CAW'(PRB_LEN - 1)) ? '0 : r_coef_addr + 1'b1;
            end
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign err_bw       = r_err;
    assign rom_addr     = r_rom_addr;
    assign rom_index_bw = r_bw;
    assign coef_valid   = !w_empty;
    assign coef_addr    = r_coef_addr;
    assign coef_data    = w_empty ? '0 : w_head;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_prb_coef_loader.sv
// Directed bench for the preamble coefficient loader with a behavioural ROM.
module tb_prb_coef_loader;
    import prb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  index_bw_in;
    logic        busy;
    logic        done;
    logic        err_bw;
    logic [13:0] rom_addr;
    logic [2:0]  rom_index_bw;
    logic [23:0] rom_dat;
    logic        coef_valid;
    logic        coef_ready;
    logic [10:0] coef_addr;
    logic [23:0] coef_data;
    logic [1:0]  dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    prb_coef_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .index_bw_in  (index_bw_in),
        .busy         (busy),
        .done         (done),
        .err_bw       (err_bw),
        .rom_addr     (rom_addr),
        .rom_index_bw (rom_index_bw),
        .rom_dat      (rom_dat),
        .coef_valid   (coef_valid),
        .coef_ready   (coef_ready),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .dbg_state    (dbg_state)
    );

    // Preamble sample content: odd multiplier keeps every index distinct.
    function automatic logic [23:0] sig(input int unsigned i);
        logic [31:0] t;
        t = i * 32'h005A5A5B + 32'h00123456;
        return t[23:0];
    endfunction

    // ROM model: registered band offset, one-cycle registered read.
    logic [31:0] r_off = 32'd0;
    always @(posedge clk) begin
        r_off   <= prb_bw_offset(rom_index_bw);
        rom_dat <= sig(r_off + 32'(rom_addr));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_busy"},       busy, 0);
        check({pfx, "_done"},       done, 0);
        check({pfx, "_err_bw"},     err_bw, 0);
        check({pfx, "_coef_valid"}, coef_valid, 0);
        check({pfx, "_rom_addr"},   rom_addr, 0);
        check({pfx, "_coef_addr"},  coef_addr, 0);
        check({pfx, "_coef_data"},  coef_data, 0);
        check({pfx, "_rom_bw"},     rom_index_bw, 5);
        check({pfx, "_state"},      dbg_state, 0);
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0; 2: 50-cycle stall; 3: re-start then reset
    task automatic run_load(input logic [2:0] band, input int unsigned base, input int mode);
        int n;
        int k;
        bit pulsed;
        bit pulse_chk;
        pulsed = 0;
        pulse_chk = 0;
        @(posedge clk); #1;
        start = 1'b1;
        index_bw_in = band;
        coef_ready = (mode == 2) ? 1'b0 : 1'b1;
        n = 0;
        k = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            index_bw_in = 3'(n);
            case (mode)
                1:       coef_ready = (n % 3 == 0);
                2:       coef_ready = (n > 50);
                default: coef_ready = 1'b1;
            endcase
            if (n == 1) begin
                check("busy_t1", busy, 1);
                check("rom_bw_t1", rom_index_bw, 32'(band));
                check("err_t1", err_bw, 0);
            end
            if (n == 4) begin
                check("rom_addr_t4", rom_addr, 1);
                check("valid_t4", coef_valid, 0);
            end
            if (n == 5) check("valid_t5", coef_valid, 1);
            check("credit", ((int'(rom_addr) - k) <= 4) ? 1 : 0, 1);
            if (mode == 2 && n >= 5 && n <= 50) begin
                check("stall_valid", coef_valid, 1);
                check("stall_data", coef_data, 32'(sig(base)));
                check("stall_addr", coef_addr, 0);
            end
            if (pulsed && !pulse_chk) begin
                pulse_chk = 1;
                check("restart_bw", rom_index_bw, 32'(band));
                check("restart_busy", busy, 1);
            end
            if (coef_valid && coef_ready) begin
                check("coef_addr", coef_addr, k);
                check("coef_data", coef_data, 32'(sig(base + k)));
                k++;
            end
            if (mode == 3 && k == 500 && !pulsed) begin
                start = 1'b1;
                index_bw_in = 3'd2;
                pulsed = 1;
            end
            if (mode == 3 && k == 1000) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_reset("midrst");
                @(posedge clk); #1;
                check("midrst_flush", coef_valid, 0);
                return;
            end
            if (done) begin
                check("done_count", k, 2048);
                check("done_busy", busy, 0);
                check("done_bw", rom_index_bw, 32'(band));
                if (mode == 0) check("done_time", n, 2053);
                @(posedge clk); #1;
                check("done_pulse", done, 0);
                check("post_coef_addr", coef_addr, 0);
                check("post_rom_addr", rom_addr, 0);
                return;
            end
            if (n > 8000) begin
                check("load_timeout", k, 2048);
                return;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        index_bw_in = 3'd0;
        coef_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        // Illegal band: one err pulse, nothing else moves.
        @(posedge clk); #1;
        start = 1'b1;
        index_bw_in = 3'd6;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_pulse", err_bw, 1);
        check("err_busy", busy, 0);
        check("err_rom_addr", rom_addr, 0);
        check("err_rom_bw", rom_index_bw, 5);
        @(posedge clk); #1;
        check("err_clear", err_bw, 0);
        check("err_busy2", busy, 0);

        run_load(3'd3, 4096, 0);
        run_load(3'd0, 10240, 1);
        run_load(3'd5, 0, 2);
        run_load(3'd2, 6144, 3);
        run_load(3'd1, 8192, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
